// File: rtl/zprize_msm_pkg.sv
// zprize_msm_pkg: shared tag layout, limb width and accumulator FSM states
package zprize_msm_pkg;
  localparam int LW          = 50;
  localparam int TAG_VLD     = 0;
  localparam int TAG_FIRST   = 1;
  localparam int TAG_LAST    = 2;
  localparam int TAG_IDX_LSB = 3;
  localparam int TAG_IDX_W   = 4;
  localparam int TAG_ID_LSB  = 7;
  typedef enum logic [1:0] {ST_IDLE, ST_ACC, ST_DROP} acc_state_e;
endpackage

// File: rtl/zprize_res_fifo2.sv
// zprize_res_fifo2: two-entry result FIFO; a push that finds it full and not popping is dropped
module zprize_res_fifo2 #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic [DW-1:0] i_data,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [DW-1:0] o_data,
  output logic          o_drop
);
  logic [DW-1:0] r_m0, r_m1;
  logic          r_rd, r_wr;
  logic [1:0]    r_cnt;
  logic          w_pop, w_full, w_wr;
  assign w_pop   = o_valid & i_ready;
  assign w_full  = r_cnt == 2'd2;
  assign w_wr    = i_push & (~w_full | w_pop);
  assign o_valid = r_cnt != 2'd0;
  assign o_data  = r_rd ? r_m1 : r_m0;
  assign o_drop  = i_push & w_full & ~w_pop;
  // When full, the write slot equals the head slot, so push+pop reuses it safely
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_m0  <= '0;
      r_m1  <= '0;
      r_rd  <= 1'b0;
      r_wr  <= 1'b0;
      r_cnt <= 2'd0;
    end else begin
      if (w_wr && r_wr) r_m1 <= i_data;
      if (w_wr && !r_wr) r_m0 <= i_data;
      r_wr  <= r_wr ^ w_wr;
      r_rd  <= r_rd ^ w_pop;
      r_cnt <= r_cnt + {1'b0, w_wr} - {1'b0, w_pop};
    end
endmodule

// File: rtl/zprize_mul_acc_50.sv
// zprize_mul_acc_50: reassembles A*B from tagged limb partial products and queues results
module zprize_mul_acc_50
  import zprize_msm_pkg::*;
#(
  parameter  int W  = 384,
  parameter  int NL = 8,
  parameter  int M  = 32,
  localparam int RW = NL*LW+W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [LW+W-1:0] prod_i,
  input  logic [M-1:0]  tag_i,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [RW-1:0] out_data,
  output logic [M-8:0]  out_id,
  output logic          err_seq,
  output logic          err_ovf
);
  localparam logic [TAG_IDX_W-1:0] K_LAST = TAG_IDX_W'(NL-1);
  acc_state_e             r_state;
  logic [TAG_IDX_W-1:0]   r_exp_k;
  logic [W:0]             r_acc_hi;
  logic [RW-1:0]          r_res;
  logic [M-8:0]           r_id;
  logic                   r_push, r_err_seq, r_err_ovf;
  logic                   w_vld, w_first, w_last, w_start, w_ok, w_err, w_drop;
  logic [TAG_IDX_W-1:0]   w_k;
  logic [M-8:0]           w_id;
  logic [W:0]             w_hi;
  logic [LW+W:0]          w_sum;
  assign w_vld   = tag_i[TAG_VLD];
  assign w_first = tag_i[TAG_FIRST];
  assign w_last  = tag_i[TAG_LAST];
  assign w_k     = tag_i[TAG_IDX_LSB +: TAG_IDX_W];
  assign w_id    = tag_i[M-1:TAG_ID_LSB];
  assign w_hi    = w_first ? '0 : r_acc_hi;
  assign w_sum   = {{LW{1'b0}}, w_hi} + {1'b0, prod_i};
  assign w_start = w_vld & w_first & (w_k == '0);
  // A beat is legal when it starts a job or continues one in order, and last marks exactly the final limb
  assign w_ok    = (w_start | (w_vld & ~w_first & (r_state == ST_ACC) & (w_k == r_exp_k)))
                   & (w_last == (w_k == K_LAST));
  // Restarting mid-job is a violation even though the new job is accepted; stray beats while dropping are silent
  assign w_err   = w_vld & ((w_first & (r_state == ST_ACC)) | (~w_ok & ~(~w_first & (r_state == ST_DROP))));
  // Sequence FSM, expected limb index, push strobe and sticky error flags
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_exp_k   <= '0;
      r_push    <= 1'b0;
      r_err_seq <= 1'b0;
      r_err_ovf <= 1'b0;
      r_id      <= '0;
    end else begin
      r_push <= w_ok & w_last;
      if (w_err) r_err_seq <= 1'b1;
      if (w_drop) r_err_ovf <= 1'b1;
      if (w_vld) r_state <= w_ok ? (w_last ? ST_IDLE : ST_ACC) : (r_state == ST_IDLE ? ST_IDLE : ST_DROP);
      if (w_ok) r_exp_k <= w_k + 1'b1;
      if (w_ok && w_start) r_id <= w_id;
    end
  // Shift-and-add datapath: low limb of each sum is final, the rest carries into the next limb
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_acc_hi <= '0;
      r_res    <= '0;
    end else if (w_ok) begin
      r_acc_hi <= w_sum[LW +: W+1];
      for (int i = 0; i < NL; i++)
        if (w_k == TAG_IDX_W'(i)) r_res[i*LW +: LW] <= w_sum[LW-1:0];
      if (w_last) r_res[NL*LW +: W] <= w_sum[LW +: W];
    end
  zprize_res_fifo2 #(.DW(M-7+RW)) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .i_push  (r_push),
    .i_data  ({r_id, r_res}),
    .o_valid (out_valid),
    .i_ready (out_ready),
    .o_data  ({out_id, out_data}),
    .o_drop  (w_drop)
  );
  assign err_seq = r_err_seq;
  assign err_ovf = r_err_ovf;
endmodule
